// File: rtl/magnitude_comparator.sv
// Registered, cascadable magnitude comparator producing one-hot gt/eq/lt flags.
// Equal operands defer to the cascade inputs so stages can be chained LSB-to-MSB.
module magnitude_comparator #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             out_valid
);

  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic             core_gt;
  logic             core_lt;
  logic             found;
  logic             x_d, y_d, z_d, out_valid_d;
  logic             x_q, y_q, z_q, out_valid_q;

  // Two's complement ordering maps onto unsigned ordering once the sign bits are flipped.
  always_comb begin
    a_c = a;
    b_c = b;
    if (SIGNED != 0) begin
      a_c[WIDTH-1] = ~a[WIDTH-1];
      b_c[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  always_comb begin
    core_gt = 1'b0;
    core_lt = 1'b0;
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && (a_c[i] != b_c[i])) begin
        found   = 1'b1;
        core_gt = a_c[i];
        core_lt = b_c[i];
      end
    end
  end

  // eq_in carries no information beyond gt_in/lt_in; priority keeps the result one-hot.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      if (found) begin
        x_d = core_gt;
        y_d = 1'b0;
        z_d = core_lt;
      end else begin
        x_d = gt_in;
        y_d = ~gt_in & ~lt_in;
        z_d = lt_in & ~gt_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign z         = z_q;
  assign out_valid = out_valid_q;

  logic unused_eq_in;
  assign unused_eq_in = eq_in;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Bench for magnitude_comparator: unsigned 4-bit, signed 4-bit and 1-bit instances
// driven in lock-step, results checked through an expected-result queue.
module tb_magnitude_comparator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic [0:0] a1, b1;
  logic       gt_in, eq_in, lt_in;
  logic       ux, uy, uz, uv;
  logic       sx, sy, sz, sv;
  logic       wx, wy, wz, wv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] u;
    logic [2:0] s;
    logic [2:0] w;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] xyz;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[12];

  magnitude_comparator #(.WIDTH(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
    .x(ux), .y(uy), .z(uz), .out_valid(uv)
  );

  magnitude_comparator #(.WIDTH(4), .SIGNED(1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
    .x(sx), .y(sy), .z(sz), .out_valid(sv)
  );

  magnitude_comparator #(.WIDTH(1), .SIGNED(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
    .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
    .x(wx), .y(wy), .z(wz), .out_valid(wv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] model(input int ia, input int ib,
                                       input logic g, input logic l);
    if (ia > ib) return 3'b100;
    if (ia < ib) return 3'b001;
    if (g)       return 3'b100;
    if (l)       return 3'b001;
    return 3'b010;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                       input logic vgt, input logic veq, input logic vlt,
                       input logic vv, input logic [2:0] uexp, input string name);
    exp_t e;
    exp_t got;
    a = va; b = vb; a1 = va[0]; b1 = vb[0];
    gt_in = vgt; eq_in = veq; lt_in = vlt; in_valid = vv;
    if (vv) begin
      e.u = uexp;
      e.s = model($signed(va), $signed(vb), vgt, vlt);
      e.w = model(int'(va[0]), int'(vb[0]), vgt, vlt);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({name, "_valid"}, {uv, sv, wv}, {3{vv}});
    if (uv) begin
      if (exp_q.size() == 0) begin
        chk({name, "_queue"}, 32'd0, 32'd1);
      end else begin
        got = exp_q.pop_front();
        chk({name, "_u"}, {ux, uy, uz}, got.u);
        chk({name, "_s"}, {sx, sy, sz}, got.s);
        chk({name, "_w1"}, {wx, wy, wz}, got.w);
        chk({name, "_onehot"}, {$countones({ux, uy, uz}) == 1,
                                $countones({sx, sy, sz}) == 1,
                                $countones({wx, wy, wz}) == 1}, 3'b111);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 4'b0000, 3'b010};
    vecs[1]  = '{4'b0010, 4'b0001, 3'b100};
    vecs[2]  = '{4'b1100, 4'b1010, 3'b100};
    vecs[3]  = '{4'b1000, 4'b1110, 3'b001};
    vecs[4]  = '{4'b0101, 4'b0101, 3'b010};
    vecs[5]  = '{4'b0110, 4'b0101, 3'b100};
    vecs[6]  = '{4'b1000, 4'b1000, 3'b010};
    vecs[7]  = '{4'b1111, 4'b1100, 3'b100};
    vecs[8]  = '{4'b0010, 4'b1111, 3'b001};
    vecs[9]  = '{4'b0111, 4'b1000, 3'b001};
    vecs[10] = '{4'b1101, 4'b1110, 3'b001};
    vecs[11] = '{4'b1111, 4'b1111, 3'b010};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; a1 = '0; b1 = '0;
    gt_in = 1'b0; eq_in = 1'b1; lt_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ux, uy, uz, uv, sx, sy, sz, sv, wx, wy, wz, wv}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      drive(vecs[i].a, vecs[i].b, 1'b0, 1'b1, 1'b0, 1'b1, vecs[i].xyz, $sformatf("table%0d", i));

    // Asynchronous reset in the middle of a cycle while x is set.
    drive(4'b0110, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {ux, uy, uz, uv, sx, sy, sz, sv, wx, wy, wz, wv}, 12'h000);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, "post_reset_idle");
    chk("post_reset_xyz", {ux, uy, uz}, 3'b000);

    // Hold behaviour when in_valid drops.
    drive(4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100, "hold_load");
    drive(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, "hold_idle");
    chk("hold_xyz", {ux, uy, uz}, 3'b100);
    chk("hold_valid", uv, 1'b0);

    // Cascade resolution with equal operands.
    drive(4'b1010, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, "casc_gt");
    drive(4'b1010, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001, "casc_lt");
    drive(4'b1010, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, "casc_both");
    drive(4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, "casc_none");
    drive(4'b1011, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, "casc_ignored");

    // Signed boundaries: most-negative vs most-positive, and -1 vs -2.
    drive(4'b1000, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100, "signed_minmax");
    chk("signed_minmax_z", {sx, sy, sz}, 3'b001);
    drive(4'b1111, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100, "signed_m1m2");
    chk("signed_m1m2_x", {sx, sy, sz}, 3'b100);
    drive(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100, "ones_vs_zero");
    chk("ones_vs_zero_s", {sx, sy, sz}, 3'b001);

    // Exhaustive sweep, back-to-back, with a varying cascade vector.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] va, vb;
      logic g, l;
      va = i[7:4];
      vb = i[3:0];
      g  = i[0] ^ i[5];
      l  = i[1];
      drive(va, vb, g, ~(g | l), l, 1'b1, model(int'(va), int'(vb), g, l), "sweep");
    end

    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, "drain");
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
